// File: rtl/param_register_file.sv
// Parameterised register file with two combinational read ports, one write port
// and a self-clearing sweep that runs after reset or on request.
module param_register_file #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_req,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            clr_done
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            clr_done_q, clr_done_d;
  logic [XLEN-1:0] mem [DEPTH];
  logic            sweep_last_c;
  logic            wr_fire_c;
  logic            wr_commit_c;

  // An address is storable when it maps to a real register that is not hardwired.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(DEPTH)) && !(ZERO_REG && (a == '0));
  endfunction

  // Read path: zero while clearing or for unmapped addresses; optional forwarding.
  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    if ((state_q == ST_IDLE) && addr_ok(a)) begin
      if (BYPASS && wr_commit_c && (wr_addr == a)) v = wr_data;
      else                                         v = mem[a];
    end
    return v;
  endfunction

  assign sweep_last_c = (ptr_q == AW'(DEPTH - 1));
  assign wr_fire_c    = wr_valid && (state_q == ST_IDLE);
  assign wr_commit_c  = wr_fire_c && addr_ok(wr_addr);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (sweep_last_c) begin
          state_d    = ST_IDLE;
          ptr_d      = '0;
          clr_done_d = 1'b1;
        end
      end
      default: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Storage array is intentionally not reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR)  mem[ptr_q]   <= '0;
    else if (wr_commit_c)     mem[wr_addr] <= wr_data;
  end

  always_comb rs1_data = rd_port(rs1_addr);
  always_comb rs2_data = rd_port(rs2_addr);

  assign wr_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_CLEAR);
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: default instance (a) plus DEPTH=24, ZERO_REG=0, BYPASS=0 instance (b).
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_req, wr_valid;
  logic [4:0]  wr_addr, rs1_addr, rs2_addr;
  logic [63:0] wr_data;
  logic        wr_ready_a, busy_a, clr_done_a;
  logic        wr_ready_b, busy_b, clr_done_b;
  logic [63:0] rs1_a, rs2_a, rs1_b, rs2_b;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int ca, cb;

  always #5 clk = ~clk;

  param_register_file dut_a (
    .clk(clk), .reset(reset), .clr_req(clr_req), .wr_valid(wr_valid),
    .wr_ready(wr_ready_a), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_a), .rs2_data(rs2_a),
    .busy(busy_a), .clr_done(clr_done_a)
  );

  param_register_file #(.XLEN(64), .DEPTH(24), .AW(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .clr_req(clr_req), .wr_valid(wr_valid),
    .wr_ready(wr_ready_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_b), .rs2_data(rs2_b),
    .busy(busy_b), .clr_done(clr_done_b)
  );

  always @(negedge clk) begin
    if (clr_done_a) pulses_a++;
    if (clr_done_b) pulses_b++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until each instance leaves CLEAR; optional clr_req pulse at cycle req_at.
  task automatic measure_sweep(input int req_at, output int da, output int db);
    int cyc;
    da = 0; db = 0; cyc = 0;
    while ((da == 0 || db == 0) && cyc < 100) begin
      clr_req = (cyc == req_at);
      tick();
      cyc++;
      if (!busy_a && da == 0) begin da = cyc; check("clr_done_a_first_idle", clr_done_a, 1); end
      if (!busy_b && db == 0) begin db = cyc; check("clr_done_b_first_idle", clr_done_b, 1); end
    end
    clr_req = 1'b0;
  endtask

  task automatic write(input logic [4:0] a, input logic [63:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    reset = 1'b0; clr_req = 1'b0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; rs1_addr = 5'd3; rs2_addr = 5'd3;

    // Reset state
    repeat (3) tick();
    check("rst_busy_a", busy_a, 1);
    check("rst_wr_ready_a", wr_ready_a, 0);
    check("rst_clr_done_a", clr_done_a, 0);
    check("rst_rs1_a", rs1_a, 0);
    check("rst_busy_b", busy_b, 1);
    reset = 1'b1;
    pulses_a = 0; pulses_b = 0;
    measure_sweep(-1, ca, cb);
    check("sweep_len_a", 64'(ca), 32);
    check("sweep_len_b", 64'(cb), 24);
    tick();
    check("clr_done_a_drops", clr_done_a, 0);
    check("pulses_a", 64'(pulses_a), 1);
    check("pulses_b", 64'(pulses_b), 1);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); #1;
      check("init_zero_a1", rs1_a, 0);
      check("init_zero_a2", rs2_a, 0);
      check("init_zero_b1", rs1_b, 0);
    end

    // Same-cycle write and read of x5
    write(5'd5, 64'hDEAD_BEEF); rs1_addr = 5'd5; rs2_addr = 5'd5; #1;
    check("wr_ready_a", wr_ready_a, 1);
    check("wr_ready_b", wr_ready_b, 1);
    check("byp_rs1_a", rs1_a, 64'hDEAD_BEEF);
    check("byp_rs2_a", rs2_a, 64'hDEAD_BEEF);
    check("nobyp_rs1_b", rs1_b, 0);
    tick(); wr_valid = 1'b0; #1;
    check("x5_a", rs1_a, 64'hDEAD_BEEF);
    check("x5_b", rs2_b, 64'hDEAD_BEEF);

    // x0 write: discarded when hardwired, stored otherwise
    write(5'd0, 64'h1234); rs1_addr = 5'd0; #1;
    check("x0_wr_ready_a", wr_ready_a, 1);
    check("x0_byp_a", rs1_a, 0);
    check("x0_old_b", rs1_b, 0);
    tick(); wr_valid = 1'b0; rs2_addr = 5'd5; #1;
    check("x0_a", rs1_a, 0);
    check("x0_b", rs1_b, 64'h1234);
    check("indep_rs2_a", rs2_a, 64'hDEAD_BEEF);
    check("indep_rs2_b", rs2_b, 64'hDEAD_BEEF);

    // Address 30: real in a, unmapped in b; address 23 is b's last register
    write(5'd30, 64'h5555); rs1_addr = 5'd30; #1;
    check("x30_byp_a", rs1_a, 64'h5555);
    check("x30_byp_b", rs1_b, 0);
    tick(); write(5'd23, 64'h77); #1;
    check("x30_a", rs1_a, 64'h5555);
    check("x30_b", rs1_b, 0);
    tick(); wr_valid = 1'b0; rs1_addr = 5'd23; #1;
    check("x23_a", rs1_a, 64'h77);
    check("x23_b", rs1_b, 64'h77);

    // Write x7 together with clr_req, then a clr_req pulse mid-sweep
    write(5'd7, 64'hAA); clr_req = 1'b1; #1;
    check("pre_clr_busy_a", busy_a, 0);
    tick(); wr_valid = 1'b0; clr_req = 1'b0; rs1_addr = 5'd5; #1;
    check("clr_busy_a", busy_a, 1);
    check("clr_busy_b", busy_b, 1);
    check("clr_wr_ready_a", wr_ready_a, 0);
    check("clr_rd_zero_a", rs1_a, 0);
    pulses_a = 0; pulses_b = 0;
    measure_sweep(10, ca, cb);
    check("req_sweep_a", 64'(ca), 32);
    check("req_sweep_b", 64'(cb), 24);
    tick();
    check("req_pulses_a", 64'(pulses_a), 1);
    check("req_pulses_b", 64'(pulses_b), 1);
    rs1_addr = 5'd7; rs2_addr = 5'd5; #1;
    check("x7_cleared_a", rs1_a, 0);
    check("x5_cleared_a", rs2_a, 0);
    check("x7_cleared_b", rs1_b, 0);
    rs1_addr = 5'd30; rs2_addr = 5'd0; #1;
    check("x30_cleared_a", rs1_a, 0);
    check("x0_cleared_b", rs2_b, 0);

    // Reset mid-sweep at cycle 10, held 2 cycles
    write(5'd9, 64'h99); tick(); wr_valid = 1'b0;
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (10) tick();
    reset = 1'b0; #1;
    check("mid_rst_busy_a", busy_a, 1);
    check("mid_rst_wr_ready_a", wr_ready_a, 0);
    check("mid_rst_clr_done_a", clr_done_a, 0);
    repeat (2) tick();
    reset = 1'b1;
    pulses_a = 0; pulses_b = 0;
    measure_sweep(-1, ca, cb);
    check("rst_sweep_a", 64'(ca), 32);
    check("rst_sweep_b", 64'(cb), 24);
    tick();
    check("rst_pulses_a", 64'(pulses_a), 1);
    check("rst_pulses_b", 64'(pulses_b), 1);
    rs1_addr = 5'd9; #1;
    check("x9_cleared_a", rs1_a, 0);
    check("x9_cleared_b", rs1_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
